// File: rtl/rv_decode_pkg.sv
`default_nettype none
// =====================================================================
// rv_decode_pkg : RV32/64 decode types, opcode constants and helpers
// Revision      : 1.0
// =====================================================================
package rv_decode_pkg;

  typedef enum logic [2:0] {
    FMT_R     = 3'd0,
    FMT_I     = 3'd1,
    FMT_S     = 3'd2,
    FMT_B     = 3'd3,
    FMT_U     = 3'd4,
    FMT_J     = 3'd5,
    FMT_FENCE = 3'd6,
    FMT_NONE  = 3'd7
  } fmt_e;

  localparam logic [6:0] OPC_LUI      = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC    = 7'b0010111;
  localparam logic [6:0] OPC_JAL      = 7'b1101111;
  localparam logic [6:0] OPC_JALR     = 7'b1100111;
  localparam logic [6:0] OPC_LOAD     = 7'b0000011;
  localparam logic [6:0] OPC_OP_IMM   = 7'b0010011;
  localparam logic [6:0] OPC_SYSTEM   = 7'b1110011;
  localparam logic [6:0] OPC_BRANCH   = 7'b1100011;
  localparam logic [6:0] OPC_STORE    = 7'b0100011;
  localparam logic [6:0] OPC_OP       = 7'b0110011;
  localparam logic [6:0] OPC_MISC_MEM = 7'b0001111;

  // Every RV immediate is a 32-bit value sign-extended from bit 31, so the
  // decoded record keeps that canonical form and the stage widens it to XLEN.
  localparam int IMM_W = 32;

  typedef struct packed {
    fmt_e             fmt;
    logic             illegal;
    logic [4:0]       rd;
    logic [4:0]       rs1;
    logic [4:0]       rs2;
    logic             rd_we;
    logic             rs1_en;
    logic             rs2_en;
    logic [IMM_W-1:0] imm;
  } dec_t;

  function automatic logic is_32bit_encoding(input logic [31:0] instr);
    return instr[1:0] == 2'b11;
  endfunction

endpackage
`default_nettype wire

// File: rtl/decode_fields.sv
`default_nettype none
// =====================================================================
// decode_fields : combinational RV instruction word -> decoded record
// Revision      : 1.0
// =====================================================================
module decode_fields
  import rv_decode_pkg::*;
(
  input  logic [31:0] i_instr,
  output dec_t        o_dec
);

  logic [IMM_W-1:0] w_imm_i, w_imm_s, w_imm_b, w_imm_u, w_imm_j;
  logic [IMM_W-1:0] w_imm;
  fmt_e             w_fmt;
  logic             w_legal;
  logic             w_use_rd, w_use_rs1, w_use_rs2;

  assign w_imm_i = {{20{i_instr[31]}}, i_instr[31:20]};
  assign w_imm_s = {{20{i_instr[31]}}, i_instr[31:25], i_instr[11:7]};
  assign w_imm_b = {{19{i_instr[31]}}, i_instr[31], i_instr[7], i_instr[30:25],
                    i_instr[11:8], 1'b0};
  assign w_imm_u = {i_instr[31:12], 12'b0};
  assign w_imm_j = {{11{i_instr[31]}}, i_instr[31], i_instr[19:12], i_instr[20],
                    i_instr[30:21], 1'b0};

  always_comb begin
    w_fmt     = FMT_NONE;
    w_legal   = 1'b0;
    w_use_rd  = 1'b0;
    w_use_rs1 = 1'b0;
    w_use_rs2 = 1'b0;
    w_imm     = '0;
    if (is_32bit_encoding(i_instr)) begin
      case (i_instr[6:0])
        OPC_LUI, OPC_AUIPC: begin
          w_fmt    = FMT_U;
          w_legal  = 1'b1;
          w_use_rd = 1'b1;
          w_imm    = w_imm_u;
        end
        OPC_JAL: begin
          w_fmt    = FMT_J;
          w_legal  = 1'b1;
          w_use_rd = 1'b1;
          w_imm    = w_imm_j;
        end
        OPC_JALR, OPC_LOAD, OPC_OP_IMM, OPC_SYSTEM: begin
          w_fmt     = FMT_I;
          w_legal   = 1'b1;
          w_use_rd  = 1'b1;
          w_use_rs1 = 1'b1;
          w_imm     = w_imm_i;
        end
        OPC_BRANCH: begin
          w_fmt     = FMT_B;
          w_legal   = 1'b1;
          w_use_rs1 = 1'b1;
          w_use_rs2 = 1'b1;
          w_imm     = w_imm_b;
        end
        OPC_STORE: begin
          w_fmt     = FMT_S;
          w_legal   = 1'b1;
          w_use_rs1 = 1'b1;
          w_use_rs2 = 1'b1;
          w_imm     = w_imm_s;
        end
        OPC_OP: begin
          w_fmt     = FMT_R;
          w_legal   = 1'b1;
          w_use_rd  = 1'b1;
          w_use_rs1 = 1'b1;
          w_use_rs2 = 1'b1;
        end
        OPC_MISC_MEM: begin
          w_fmt   = FMT_FENCE;
          w_legal = 1'b1;
        end
        default: begin
          w_fmt   = FMT_NONE;
          w_legal = 1'b0;
        end
      endcase
    end
  end

  // Unused fields are forced to zero so downstream never sees stale bits.
  assign o_dec.fmt     = w_fmt;
  assign o_dec.illegal = !w_legal;
  assign o_dec.rd      = w_use_rd  ? i_instr[11:7]  : 5'd0;
  assign o_dec.rs1     = w_use_rs1 ? i_instr[19:15] : 5'd0;
  assign o_dec.rs2     = w_use_rs2 ? i_instr[24:20] : 5'd0;
  assign o_dec.rd_we   = w_use_rd && (i_instr[11:7] != 5'd0);
  assign o_dec.rs1_en  = w_use_rs1;
  assign o_dec.rs2_en  = w_use_rs2;
  assign o_dec.imm     = w_imm;

endmodule
`default_nettype wire

// File: rtl/decode_stage.sv
`default_nettype none
// =====================================================================
// decode_stage : RV decode behind a two-entry skid buffer handshake
// Revision     : 1.0
// =====================================================================
module decode_stage
  import rv_decode_pkg::*;
#(
  parameter int XLEN          = 32,
  parameter bit RESET_PC_ZERO = 1'b1
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            flush,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [31:0]     in_instr,
  input  logic [XLEN-1:0] in_pc,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [XLEN-1:0] out_pc,
  output logic [2:0]      out_fmt,
  output logic [4:0]      out_rd,
  output logic [4:0]      out_rs1,
  output logic [4:0]      out_rs2,
  output logic            out_rd_we,
  output logic            out_rs1_en,
  output logic            out_rs2_en,
  output logic [XLEN-1:0] out_imm,
  output logic            out_illegal
);

  dec_t            w_dec;
  dec_t            r_dec0, r_dec1;
  logic [XLEN-1:0] r_pc0, r_pc1;
  logic [1:0]      r_count;
  logic            r_in_ready;
  logic [1:0]      w_count_nxt;
  logic            w_push, w_pop, w_load0_new, w_shift, w_load1;

  decode_fields u_decode_fields (
    .i_instr (in_instr),
    .o_dec   (w_dec)
  );

  // Entry 0 is always the head; entry 1 only fills behind a stalled head.
  assign w_push      = in_valid && r_in_ready && !flush;
  assign w_pop       = (r_count != 2'd0) && out_ready && !flush;
  assign w_load0_new = w_push && ((r_count == 2'd0) || ((r_count == 2'd1) && w_pop));
  assign w_shift     = w_pop && (r_count == 2'd2);
  assign w_load1     = w_push && (((r_count == 2'd1) && !w_pop) ||
                                  ((r_count == 2'd2) && w_pop));

  always_comb begin
    w_count_nxt = r_count;
    if (flush) begin
      w_count_nxt = 2'd0;
    end else if (w_push && !w_pop) begin
      w_count_nxt = r_count + 2'd1;
    end else if (!w_push && w_pop) begin
      w_count_nxt = r_count - 2'd1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_count    <= 2'd0;
      r_in_ready <= 1'b0;
    end else begin
      r_count    <= w_count_nxt;
      r_in_ready <= (w_count_nxt != 2'd2);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_dec0 <= '0;
      r_dec1 <= '0;
    end else begin
      if (w_load0_new) begin
        r_dec0 <= w_dec;
      end else if (w_shift) begin
        r_dec0 <= r_dec1;
      end
      if (w_load1) begin
        r_dec1 <= w_dec;
      end
    end
  end

  if (RESET_PC_ZERO) begin : g_pc_rst
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        r_pc0 <= '0;
        r_pc1 <= '0;
      end else begin
        if (w_load0_new) begin
          r_pc0 <= in_pc;
        end else if (w_shift) begin
          r_pc0 <= r_pc1;
        end
        if (w_load1) begin
          r_pc1 <= in_pc;
        end
      end
    end
  end else begin : g_pc_norst
    always_ff @(posedge clk) begin
      if (w_load0_new) begin
        r_pc0 <= in_pc;
      end else if (w_shift) begin
        r_pc0 <= r_pc1;
      end
      if (w_load1) begin
        r_pc1 <= in_pc;
      end
    end
  end

  if (XLEN == 64) begin : g_imm64
    assign out_imm = {{32{r_dec0.imm[IMM_W-1]}}, r_dec0.imm};
  end else if (XLEN == 32) begin : g_imm32
    assign out_imm = r_dec0.imm;
  end else begin : g_bad_xlen
    $error("decode_stage: XLEN must be 32 or 64");
  end

  assign in_ready    = r_in_ready;
  assign out_valid   = (r_count != 2'd0);
  assign out_pc      = r_pc0;
  assign out_fmt     = r_dec0.fmt;
  assign out_rd      = r_dec0.rd;
  assign out_rs1     = r_dec0.rs1;
  assign out_rs2     = r_dec0.rs2;
  assign out_rd_we   = r_dec0.rd_we;
  assign out_rs1_en  = r_dec0.rs1_en;
  assign out_rs2_en  = r_dec0.rs2_en;
  assign out_illegal = r_dec0.illegal;

endmodule
`default_nettype wire

// File: tb/tb_decode_stage.sv
`default_nettype none
// =====================================================================
// tb_decode_stage : directed bench with a queue-based reference model
// Revision        : 1.0
// =====================================================================
module tb_decode_stage;

  localparam int F_R = 0, F_I = 1, F_S = 2, F_B = 3, F_U = 4, F_J = 5, F_FENCE = 6, F_NONE = 7;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        flush = 1'b0;
  logic        in_valid = 1'b0;
  logic        out_ready = 1'b0;
  logic [31:0] in_instr = '0;
  logic [63:0] in_pc = '0;

  logic        rdy32, ov32, rdwe32, r1en32, r2en32, ill32;
  logic [31:0] pc32, imm32;
  logic [2:0]  fmt32;
  logic [4:0]  rd32, rs132, rs232;
  logic        rdy64, ov64, rdwe64, r1en64, r2en64, ill64;
  logic [63:0] pc64, imm64;
  logic [2:0]  fmt64;
  logic [4:0]  rd64, rs164, rs264;

  always #5 clk = ~clk;

  decode_stage #(.XLEN(32), .RESET_PC_ZERO(1'b1)) dut (
    .clk(clk), .rst_n(rst_n), .flush(flush), .in_valid(in_valid), .in_ready(rdy32),
    .in_instr(in_instr), .in_pc(in_pc[31:0]), .out_valid(ov32), .out_ready(out_ready),
    .out_pc(pc32), .out_fmt(fmt32), .out_rd(rd32), .out_rs1(rs132), .out_rs2(rs232),
    .out_rd_we(rdwe32), .out_rs1_en(r1en32), .out_rs2_en(r2en32), .out_imm(imm32),
    .out_illegal(ill32)
  );

  decode_stage #(.XLEN(64), .RESET_PC_ZERO(1'b1)) dut64 (
    .clk(clk), .rst_n(rst_n), .flush(flush), .in_valid(in_valid), .in_ready(rdy64),
    .in_instr(in_instr), .in_pc(in_pc), .out_valid(ov64), .out_ready(out_ready),
    .out_pc(pc64), .out_fmt(fmt64), .out_rd(rd64), .out_rs1(rs164), .out_rs2(rs264),
    .out_rd_we(rdwe64), .out_rs1_en(r1en64), .out_rs2_en(r2en64), .out_imm(imm64),
    .out_illegal(ill64)
  );

  typedef struct {
    int          fmt;
    logic [4:0]  rd, rs1, rs2;
    logic        rd_we, rs1_en, rs2_en, ill;
    longint      imm;
    logic [63:0] pc;
  } exp_t;

  int   n_chk = 0, n_err = 0, n_acc = 0, n_emit = 0;
  exp_t q[$];
  exp_t m_e;
  bit   m_rdy = 1'b0;
  logic [63:0] m_imm;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Reference decode straight from the ISA field definitions, using arithmetic.
  function automatic exp_t model(input logic [31:0] w, input logic [63:0] pc);
    exp_t   e;
    bit     ur, u1, u2;
    int     f;
    longint v;
    ur = 0; u1 = 0; u2 = 0; v = 0; f = F_NONE;
    if (w[1:0] == 2'b11) begin
      case (w[6:0])
        7'h37, 7'h17:               f = F_U;
        7'h6F:                      f = F_J;
        7'h67, 7'h03, 7'h13, 7'h73: f = F_I;
        7'h63:                      f = F_B;
        7'h23:                      f = F_S;
        7'h33:                      f = F_R;
        7'h0F:                      f = F_FENCE;
        default:                    f = F_NONE;
      endcase
    end
    case (f)
      F_R: begin ur = 1; u1 = 1; u2 = 1; end
      F_I: begin
        ur = 1; u1 = 1;
        v = longint'(w[31:20]);
        if (w[31]) v = v - 4096;
      end
      F_S: begin
        u1 = 1; u2 = 1;
        v = longint'(w[31:25]) * 32 + longint'(w[11:7]);
        if (w[31]) v = v - 4096;
      end
      F_B: begin
        u1 = 1; u2 = 1;
        v = longint'(w[7]) * 2048 + longint'(w[30:25]) * 32 + longint'(w[11:8]) * 2;
        if (w[31]) v = v - 4096;
      end
      F_U: begin
        ur = 1;
        v = longint'(w[31:12]) * 4096;
        if (w[31]) v = v - 64'sd4294967296;
      end
      F_J: begin
        ur = 1;
        v = longint'(w[19:12]) * 4096 + longint'(w[20]) * 2048 + longint'(w[30:21]) * 2;
        if (w[31]) v = v - 1048576;
      end
      default: ;
    endcase
    e.fmt    = f;
    e.ill    = (f == F_NONE);
    e.rd     = ur ? w[11:7] : 5'd0;
    e.rs1    = u1 ? w[19:15] : 5'd0;
    e.rs2    = u2 ? w[24:20] : 5'd0;
    e.rd_we  = ur && (w[11:7] != 5'd0);
    e.rs1_en = u1;
    e.rs2_en = u2;
    e.imm    = v;
    e.pc     = pc;
    return e;
  endfunction

  always @(posedge clk) begin
    if (rst_n) begin
      if (in_valid && rdy32 && !flush) n_acc++;
      if (ov32 && out_ready) n_emit++;
    end
  end

  // Compare process: inputs only change just after rising edges, so the
  // values seen here are the ones the next rising edge will act on.
  always @(negedge clk) begin
    if (!rst_n) begin
      chk("rst_out_valid", ov32, 0);
      chk("rst_in_ready", rdy32, 0);
      chk("rst_pc", pc32, 0);
      chk("rst_fmt", fmt32, 0);
      chk("rst_regs", {rd32, rs132, rs232}, 0);
      chk("rst_flags", {rdwe32, r1en32, r2en32, ill32}, 0);
      chk("rst_imm", imm32, 0);
      chk("rst_valid64", ov64, 0);
      chk("rst_pc64", pc64, 0);
      chk("rst_imm64", imm64, 0);
      q.delete();
      m_rdy = 1'b0;
    end else begin
      chk("in_ready", rdy32, m_rdy);
      chk("out_valid", ov32, q.size() > 0);
      chk("in_ready64", rdy64, m_rdy);
      chk("out_valid64", ov64, q.size() > 0);
      if (q.size() > 0) begin
        m_e   = q[0];
        m_imm = m_e.imm;
        chk("m_fmt", fmt32, m_e.fmt);
        chk("m_rd", rd32, m_e.rd);
        chk("m_rs1", rs132, m_e.rs1);
        chk("m_rs2", rs232, m_e.rs2);
        chk("m_rd_we", rdwe32, m_e.rd_we);
        chk("m_rs1_en", r1en32, m_e.rs1_en);
        chk("m_rs2_en", r2en32, m_e.rs2_en);
        chk("m_illegal", ill32, m_e.ill);
        chk("m_imm", imm32, {32'b0, m_imm[31:0]});
        chk("m_pc", pc32, {32'b0, m_e.pc[31:0]});
        chk("m_fmt64", fmt64, m_e.fmt);
        chk("m_imm64", imm64, m_imm);
        chk("m_pc64", pc64, m_e.pc);
      end
      if (flush) begin
        q.delete();
      end else begin
        if (q.size() > 0 && out_ready) void'(q.pop_front());
        if (in_valid && m_rdy) q.push_back(model(in_instr, in_pc));
      end
      m_rdy = (q.size() < 2);
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send1(input logic [31:0] ins, input logic [63:0] pc);
    tick();
    in_valid = 1'b1; in_instr = ins; in_pc = pc; out_ready = 1'b1;
    tick();
    in_valid = 1'b0;
    @(negedge clk);
  endtask

  logic [31:0] vec [8];

  task automatic run_stream(input int n, input int stall, input logic [31:0] rmask,
                            input bit chk_fill);
    int idx, a0, e0;
    bit done;
    tick();
    idx = 0; a0 = n_acc; e0 = n_emit; done = 1'b0;
    for (int c = 0; c < 200 && !done; c++) begin
      if (chk_fill && c == stall) begin
        chk("fill_accepted", n_acc - a0, 2);
        chk("fill_in_ready", rdy32, 0);
      end
      in_valid  = (idx < n);
      in_instr  = (idx < n) ? vec[idx] : 32'h0;
      in_pc     = 64'hA5A5_0000_0000_2000 + 64'(4 * idx);
      out_ready = (c < stall) ? 1'b0 : rmask[c % 32];
      @(posedge clk);
      if (in_valid && rdy32) idx++;
      #1;
      done = (idx == n) && (n_emit - e0 == n);
    end
    in_valid = 1'b0; out_ready = 1'b0;
    chk("stream_emitted", n_emit - e0, n);
  endtask

  task automatic fill_two();
    tick();
    out_ready = 1'b0;
    in_valid = 1'b1; in_instr = 32'h002081B3; in_pc = 64'h3000;
    tick();
    in_instr = 32'h0020A423; in_pc = 64'h3004;
    tick();
  endtask

  logic [31:0] misc [10] = '{32'h002081B3, 32'h0020A423, 32'h008000EF, 32'h0FF0000F,
                             32'h12345297, 32'h0000A003, 32'hFFFFFFFE, 32'h00000057,
                             32'h00000073, 32'hFF8100E7};

  initial begin
    int e0;
    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    tick();
    chk("ready_after_reset", rdy32, 1);
    chk("valid_after_reset", ov32, 0);

    send1(32'hFFF00093, 64'h1000);
    chk("addi_valid", ov32, 1);
    chk("addi_fmt", fmt32, F_I);
    chk("addi_rd", rd32, 1);
    chk("addi_rs1", rs132, 0);
    chk("addi_rd_we", rdwe32, 1);
    chk("addi_imm", imm32, 64'hFFFF_FFFF);

    send1(32'hFE000EE3, 64'h1004);
    chk("beq_fmt", fmt32, F_B);
    chk("beq_rd_we", rdwe32, 0);
    chk("beq_rs_en", {r1en32, r2en32}, 2'b11);
    chk("beq_imm", imm32, 64'hFFFF_FFFC);

    send1(32'h800000B7, 64'hFFFF_0000_0000_1008);
    chk("lui64_fmt", fmt64, F_U);
    chk("lui64_rd", rd64, 1);
    chk("lui64_imm", imm64, 64'hFFFF_FFFF_8000_0000);
    chk("lui32_imm", imm32, 64'h8000_0000);

    send1(32'h00000000, 64'h0000_0001_0000_1234);
    chk("zero_illegal", ill32, 1);
    chk("zero_fmt", fmt32, F_NONE);
    chk("zero_regs", {rd32, rs132, rs232}, 0);
    chk("zero_flags", {rdwe32, r1en32, r2en32}, 0);
    chk("zero_imm", imm32, 0);
    chk("zero_pc", pc32, 64'h1234);
    chk("zero_pc64", pc64, 64'h0000_0001_0000_1234);

    send1(32'hFE532A23, 64'h1010);
    chk("sw_neg_fmt", fmt32, F_S);
    chk("sw_neg_rs", {rs132, rs232}, {5'd6, 5'd5});
    chk("sw_neg_imm64", imm64, 64'hFFFF_FFFF_FFFF_FFF4);

    for (int i = 0; i < 10; i++) send1(misc[i], 64'h2000 + 64'(4 * i));

    vec = '{32'h00100093, 32'h00200113, 32'h002081B3, 32'h0020A423,
            32'hFE000EE3, 32'h0, 32'h0, 32'h0};
    run_stream(5, 4, 32'hFFFF_FFFF, 1'b1);

    vec = '{32'h12345297, 32'h008000EF, 32'hFFFFFFFE, 32'h0FF0000F,
            32'hFF8100E7, 32'h0000A003, 32'h00000057, 32'hFE532A23};
    run_stream(8, 0, 32'b1011_0010_1110_0110_1101_0011_1001_0111, 1'b0);
    run_stream(8, 0, 32'hFFFF_FFFF, 1'b0);

    e0 = n_emit;
    fill_two();
    in_instr = 32'hFFF00093; in_pc = 64'h3008; flush = 1'b1;
    tick();
    flush = 1'b0; in_valid = 1'b0;
    @(negedge clk);
    chk("flush_out_valid", ov32, 0);
    chk("flush_in_ready", rdy32, 1);
    tick();
    out_ready = 1'b1;
    repeat (4) tick();
    chk("flush_no_emit", n_emit - e0, 0);

    e0 = n_emit;
    fill_two();
    in_instr = 32'hFFF00093; in_pc = 64'h3008; rst_n = 1'b0;
    @(negedge clk);
    chk("rstpulse_out_valid", ov32, 0);
    tick();
    rst_n = 1'b1; in_valid = 1'b0;
    tick();
    chk("rstpulse_in_ready", rdy32, 1);
    chk("rstpulse_valid", ov32, 0);
    out_ready = 1'b1;
    repeat (4) tick();
    chk("rstpulse_no_emit", n_emit - e0, 0);

    send1(32'h002081B3, 64'h4000);
    chk("post_reset_fmt", fmt32, F_R);
    chk("post_reset_regs", {rd32, rs132, rs232}, {5'd3, 5'd1, 5'd2});
    tick();
    out_ready = 1'b0;
    repeat (2) tick();

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached, got no finish expected finish");
    $fatal(1, "watchdog");
  end

endmodule
`default_nettype wire
